// File: rtl/accel_sample_filter_if.sv
// Sample/filter bus between the SPI accelerometer front end and the sample filter.
// master drives samples and the overrun clear; slave (the filter) drives the results.
interface accel_sample_filter_if;
    logic               sample_valid;
    logic signed [15:0] sample_data;
    logic               overrun_clr;
    logic signed [15:0] filt_data;
    logic               filt_valid;
    logic               primed;
    logic               shock;
    logic               overrun;
    logic [7:0]         bar;

    modport master (
        output sample_valid, sample_data, overrun_clr,
        input  filt_data, filt_valid, primed, shock, overrun, bar
    );

    modport slave (
        input  sample_valid, sample_data, overrun_clr,
        output filt_data, filt_valid, primed, shock, overrun, bar
    );
endinterface

// File: rtl/accel_sample_filter.sv
// Moving-average filter, shock detector and tilt bar for one accelerometer axis.
// Shock detection is built only when ACCEL_SHOCK_EN is defined; otherwise shock is tied low.
module accel_sample_filter #(
    parameter int unsigned AVG_LOG2     = 3,
    parameter logic [15:0] SHOCK_THRESH = 16'd200,
    parameter logic [23:0] SHOCK_HOLD   = 24'd5000000,
    parameter logic [3:0]  BAR_SHIFT    = 4'd6
) (
    input  logic                 clk,
    input  logic                 reset,
    accel_sample_filter_if.slave sif
);
    localparam int unsigned        WIN     = 1 << AVG_LOG2;
    localparam int unsigned        AW      = 16 + AVG_LOG2;
    localparam logic [AVG_LOG2:0]  WIN_CNT = {1'b1, {AVG_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    logic [1:0]           state;
    logic signed [15:0]   new_sample;
    logic signed [15:0]   ring [WIN];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic [AVG_LOG2-1:0]  wr_ptr;
    logic [AVG_LOG2:0]    fill_cnt;
    logic [AVG_LOG2:0]    fill_next;
    logic signed [15:0]   filt_data;
    logic signed [15:0]   filt_next;
    logic                 filt_valid;
    logic                 overrun;
    logic [7:0]           bar;
    logic                 drop;
    logic                 primed;

    function automatic logic [7:0] bar_of(input logic signed [15:0] f);
        logic signed [15:0] lvl;
        logic [7:0]         b;
        lvl  = f >>> BAR_SHIFT;
        b[4] = (lvl >= 16'sd1);
        b[5] = (lvl >= 16'sd2);
        b[6] = (lvl >= 16'sd3);
        b[7] = (lvl >= 16'sd4);
        b[3] = (lvl <= -16'sd1);
        b[2] = (lvl <= -16'sd2);
        b[1] = (lvl <= -16'sd3);
        b[0] = (lvl <= -16'sd4);
        if (lvl == 16'sd0) begin
            b = 8'b0001_1000;
        end
        return b;
    endfunction

    assign primed = (fill_cnt == WIN_CNT);
    assign drop   = sif.sample_valid && (state != ST_IDLE);

    // The average is computed from acc_next so the registered outputs land while in OUTPUT.
    always_comb begin
        acc_next  = acc + {{AVG_LOG2{new_sample[15]}}, new_sample}
                        - {{AVG_LOG2{ring[wr_ptr][15]}}, ring[wr_ptr]};
        filt_next = 16'(acc_next >>> AVG_LOG2);
        fill_next = primed ? fill_cnt : fill_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            new_sample <= '0;
            for (int unsigned i = 0; i < WIN; i++) begin
                ring[i] <= '0;
            end
            acc        <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            filt_data  <= '0;
            filt_valid <= 1'b0;
            overrun    <= 1'b0;
            bar        <= 8'b0001_1000;
        end else begin
            filt_valid <= 1'b0;
            if (drop) begin
                overrun <= 1'b1;
            end else if (sif.overrun_clr) begin
                overrun <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (sif.sample_valid) begin
                        new_sample <= sif.sample_data;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc          <= acc_next;
                    ring[wr_ptr] <= new_sample;
                    wr_ptr       <= wr_ptr + 1'b1;
                    fill_cnt     <= fill_next;
                    filt_data    <= filt_next;
                    filt_valid   <= (fill_next == WIN_CNT);
                    bar          <= bar_of(filt_next);
                    state        <= ST_OUTPUT;
                end
                ST_OUTPUT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign sif.filt_data  = filt_data;
    assign sif.filt_valid = filt_valid;
    assign sif.primed     = primed;
    assign sif.overrun    = overrun;
    assign sif.bar        = bar;

`ifdef ACCEL_SHOCK_EN
    logic signed [16:0] diff;
    logic [16:0]        mag;
    logic               hit;
    logic [23:0]        hold_cnt;
    logic               shock;

    // filt_data still holds the previous average during ACCUM.
    always_comb begin
        diff = {new_sample[15], new_sample} - {filt_data[15], filt_data};
        mag  = diff[16] ? -diff : diff;
        hit  = (state == ST_ACCUM) && primed && (mag > {1'b0, SHOCK_THRESH});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            shock    <= 1'b0;
        end else if (hit) begin
            hold_cnt <= SHOCK_HOLD;
            shock    <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == 24'd1) begin
                shock <= 1'b0;
            end
        end
    end

    assign sif.shock = shock;
`else
    logic unused_shock_params;
    assign unused_shock_params = ^{SHOCK_THRESH, SHOCK_HOLD};
    assign sif.shock = 1'b0;
`endif
endmodule

// File: tb/tb_accel_sample_filter.sv
// Self-checking bench for accel_sample_filter: constant vector table, hand-written corner
// sequences and randomized samples checked against a queue-based moving-average model.
module tb_accel_sample_filter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accel_sample_filter_if bus ();

    accel_sample_filter #(
        .AVG_LOG2    (3),
        .SHOCK_THRESH(16'd200),
        .SHOCK_HOLD  (24'd100),
        .BAR_SHIFT   (4'd6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (bus)
    );

    // Reference model: the last eight real samples, newest at the back.
    int hist[$];
    int m_filt;
    bit m_ovr;
    bit m_hit_seen;
    int m_hit_edge;

    typedef struct {
        int         sample;
        bit         exp_valid;
        int         exp_filt;
        logic [7:0] exp_bar;
        bit         exp_primed;
    } vec_t;
    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] model_bar(input int f);
        int lvl;
        lvl = floor_div(f, 64);
        if (lvl > 4)  lvl = 4;
        if (lvl < -4) lvl = -4;
        if (lvl == 0) return 8'b0001_1000;
        if (lvl > 0)  return 8'(((1 << lvl) - 1) << 4);
        return 8'((8'hF0 >> (-lvl)) & 8'h0F);
    endfunction

    function automatic bit exp_shock();
`ifdef ACCEL_SHOCK_EN
        return m_hit_seen && ((cyc - m_hit_edge) < 100);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_filt     = 0;
        m_ovr      = 1'b0;
        m_hit_seen = 1'b0;
        m_hit_edge = 0;
    endfunction

    function automatic void model_push(input int v);
        int sum;
        hist.push_back(v);
        if (hist.size() > 8) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        m_filt = floor_div(sum, 8);
    endfunction

    task automatic check_all(input string tag, input bit exp_fv);
        check({tag, " filt_valid"}, int'(bus.filt_valid), int'(exp_fv));
        check({tag, " filt_data"},  int'(bus.filt_data), m_filt);
        check({tag, " primed"},     int'(bus.primed), int'(hist.size() == 8));
        check({tag, " bar"},        int'(bus.bar), int'(model_bar(m_filt)));
        check({tag, " shock"},      int'(bus.shock), int'(exp_shock()));
        check({tag, " overrun"},    int'(bus.overrun), int'(m_ovr));
    endtask

    task automatic do_reset(input int n);
        bus.sample_valid = 1'b0;
        bus.overrun_clr  = 1'b0;
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            tick();
            check({tag, " idle shock"}, int'(bus.shock), int'(exp_shock()));
            check({tag, " idle filt_valid"}, int'(bus.filt_valid), 0);
        end
    endtask

    task automatic clear_ovr(input string tag);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        m_ovr = 1'b0;
        check({tag, " overrun cleared"}, int'(bus.overrun), 0);
    endtask

    // Starts and ends with the DUT idle, just after a clock edge; checks at T+2 and T+3.
    task automatic send(input int v, input int junk, input bit drop1, input bit clr1,
                        input bit drop2, input string tag,
                        output int got_filt, output logic [7:0] got_bar,
                        output bit got_valid, output bit got_primed);
        logic signed [15:0] s16;
        int sv;
        s16 = 16'(v);
        sv  = s16;
        bus.sample_valid = 1'b1;
        bus.sample_data  = s16;
        tick();
        bus.sample_valid = drop1;
        bus.sample_data  = 16'(junk);
        bus.overrun_clr  = clr1;
        tick();
        bus.overrun_clr  = 1'b0;
`ifdef ACCEL_SHOCK_EN
        if (hist.size() == 8 && (sv - m_filt > 200 || m_filt - sv > 200)) begin
            m_hit_seen = 1'b1;
            m_hit_edge = cyc;
        end
`endif
        model_push(sv);
        if (drop1)     m_ovr = 1'b1;
        else if (clr1) m_ovr = 1'b0;
        check_all(tag, hist.size() == 8);
        got_filt   = int'(bus.filt_data);
        got_bar    = bus.bar;
        got_valid  = bus.filt_valid;
        got_primed = bus.primed;
        bus.sample_valid = drop2;
        tick();
        bus.sample_valid = 1'b0;
        if (drop2) m_ovr = 1'b1;
        check({tag, " pulse end"}, int'(bus.filt_valid), 0);
        check({tag, " overrun T+3"}, int'(bus.overrun), int'(m_ovr));
    endtask

    task automatic send_simple(input int v, input string tag);
        int gf;
        logic [7:0] gb;
        bit gv, gp;
        send(v, 0, 1'b0, 1'b0, 1'b0, tag, gf, gb, gv, gp);
    endtask

    initial begin
        int gf;
        logic [7:0] gb;
        bit gv, gp;

        // 8x320, then 8x-128 wrapping the window; expectations worked by hand.
        vecs[0]  = '{320, 1'b0,   40, 8'h18, 1'b0};
        vecs[1]  = '{320, 1'b0,   80, 8'h10, 1'b0};
        vecs[2]  = '{320, 1'b0,  120, 8'h10, 1'b0};
        vecs[3]  = '{320, 1'b0,  160, 8'h30, 1'b0};
        vecs[4]  = '{320, 1'b0,  200, 8'h70, 1'b0};
        vecs[5]  = '{320, 1'b0,  240, 8'h70, 1'b0};
        vecs[6]  = '{320, 1'b0,  280, 8'hF0, 1'b0};
        vecs[7]  = '{320, 1'b1,  320, 8'hF0, 1'b1};
        vecs[8]  = '{-128, 1'b1, 264, 8'hF0, 1'b1};
        vecs[9]  = '{-128, 1'b1, 208, 8'h70, 1'b1};
        vecs[10] = '{-128, 1'b1, 152, 8'h30, 1'b1};
        vecs[11] = '{-128, 1'b1,  96, 8'h10, 1'b1};
        vecs[12] = '{-128, 1'b1,  40, 8'h18, 1'b1};
        vecs[13] = '{-128, 1'b1, -16, 8'h08, 1'b1};
        vecs[14] = '{-128, 1'b1, -72, 8'h0C, 1'b1};
        vecs[15] = '{-128, 1'b1, -128, 8'h0C, 1'b1};

        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.overrun_clr  = 1'b0;

        do_reset(2);
        check_all("reset", 1'b0);

        foreach (vecs[i]) begin
            send(vecs[i].sample, 0, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i), gf, gb, gv, gp);
            check($sformatf("vec%0d tbl filt", i),   gf, vecs[i].exp_filt);
            check($sformatf("vec%0d tbl bar", i),    int'(gb), int'(vecs[i].exp_bar));
            check($sformatf("vec%0d tbl valid", i),  int'(gv), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d tbl primed", i), int'(gp), int'(vecs[i].exp_primed));
            idle(7, "vec gap");
        end

        // Back-to-back strobes: only the first is accumulated.
        send(5, 7, 1'b1, 1'b0, 1'b0, "b2b", gf, gb, gv, gp);
        check("b2b filt", gf, floor_div(-128 * 7 + 5, 8));
        idle(2, "b2b");
        clear_ovr("b2b");
        // A drop in the same cycle as overrun_clr keeps overrun set.
        send(3, 9, 1'b1, 1'b1, 1'b0, "set+clr", gf, gb, gv, gp);
        check("set+clr overrun", int'(bus.overrun), 1);
        clear_ovr("set+clr");
        send(11, 0, 1'b0, 1'b0, 1'b1, "drop in OUTPUT", gf, gb, gv, gp);
        clear_ovr("drop in OUTPUT");

        // Shock threshold boundary, hold time and retrigger.
        do_reset(2);
        for (int i = 0; i < 8; i++) send_simple(0, "prime0");
        send_simple(200, "thresh 200");
        idle(3, "thresh 200");
        do_reset(2);
        for (int i = 0; i < 8; i++) send_simple(0, "prime0b");
        send_simple(201, "shock 201");
        idle(48, "hold1");
        send_simple(260, "retrigger");
        idle(110, "hold2");

        // Reset while in ACCUM discards the sample.
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'sd50;
        tick();
        bus.sample_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_all("mid reset", 1'b0);
        for (int i = 0; i < 8; i++) send_simple(int'($urandom_range(0, 400)) - 200, $sformatf("refill%0d", i));

        for (int i = 0; i < 300; i++) begin
            int v;
            bit d1, c1, d2;
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
            else                           v = int'($urandom_range(0, 1200)) - 600;
            d1 = ($urandom_range(0, 9) == 0);
            c1 = ($urandom_range(0, 9) == 0);
            d2 = ($urandom_range(0, 9) == 0);
            send(v, int'($urandom_range(0, 65535)), d1, c1, d2, $sformatf("rnd%0d", i), gf, gb, gv, gp);
            idle($urandom_range(0, 4), "rnd");
            if ($urandom_range(0, 7) == 0) clear_ovr("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end
endmodule
